// File: rtl/mips_debug_pkg.sv
// Shared debug-frame command codes, FSM state encoding and default widths
// for the MIPS run controller.
package mips_debug_pkg;

  localparam int NB_CODE_DEFAULT        = 6;
  localparam int NB_CYCLE_COUNT_DEFAULT = 32;

  localparam logic [5:0] CODE_START    = 6'b000001;
  localparam logic [5:0] CODE_RESET    = 6'b000010;
  localparam logic [5:0] CODE_SET_MODE = 6'b001010;
  localparam logic [5:0] CODE_STEP     = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESETTING = 3'd1,
    ST_READY     = 3'd2,
    ST_RUN_CONT  = 3'd3,
    ST_STEP_WAIT = 3'd4,
    ST_STEP_EXEC = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;

  function automatic logic is_enabled_state(input state_t s);
    return (s == ST_RUN_CONT) || (s == ST_STEP_EXEC);
  endfunction

  function automatic logic is_mode_change_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_READY) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/mips_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !(&r_count)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mips_run_controller.sv
// Debug run controller: decodes edge-triggered debug commands and sequences
// reset, continuous run and single-step execution of the MIPS pipeline.
//
// state        | meaning
// IDLE         | after power-on reset, MIPS held in reset until RESET command
// RESETTING    | MIPS reset asserted for RESET_CYCLES cycles
// READY        | out of reset, waiting for START
// RUN_CONT     | pipeline enabled every cycle until HALT
// STEP_WAIT    | step mode, waiting for STEP
// STEP_EXEC    | single enabled cycle
// HALTED       | HALT retired; only RESET / SET_MODE accepted
module mips_run_controller
  import mips_debug_pkg::*;
#(
  parameter int NB_CODE        = NB_CODE_DEFAULT,
  parameter int NB_CYCLE_COUNT = NB_CYCLE_COUNT_DEFAULT,
  parameter int RESET_CYCLES   = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NB_CODE-1:0]        i_instr_code,
  input  logic                      i_instr_valid,
  input  logic                      i_mode_sel,
  input  logic                      i_halt,
  output logic                      o_mips_enable,
  output logic                      o_mips_reset,
  output logic                      o_mode,
  output logic [2:0]                o_state,
  output logic [NB_CYCLE_COUNT-1:0] o_cycle_count,
  output logic                      o_done,
  output logic                      o_cmd_error
);

  localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);

  state_t     r_state;
  logic       r_prev_valid;
  logic [3:0] r_rst_cnt;
  logic       r_mode;
  logic       r_mips_enable;
  logic       r_mips_reset;
  logic       r_done;
  logic       r_cmd_error;

  state_t     w_next_state;
  logic       w_cmd_edge;
  logic       w_cmd_start;
  logic       w_cmd_reset;
  logic       w_cmd_mode;
  logic       w_cmd_step;
  logic       w_set_mode;
  logic       w_cmd_illegal;

  // Commands fire only on the rising edge of the frame valid flag.
  assign w_cmd_edge  = i_instr_valid && !r_prev_valid;
  assign w_cmd_start = w_cmd_edge && (i_instr_code == NB_CODE'(CODE_START));
  assign w_cmd_reset = w_cmd_edge && (i_instr_code == NB_CODE'(CODE_RESET));
  assign w_cmd_mode  = w_cmd_edge && (i_instr_code == NB_CODE'(CODE_SET_MODE));
  assign w_cmd_step  = w_cmd_edge && (i_instr_code == NB_CODE'(CODE_STEP));

  always_comb begin
    w_next_state  = r_state;
    w_set_mode    = 1'b0;
    w_cmd_illegal = 1'b0;
    if (w_cmd_reset) begin
      w_next_state = ST_RESETTING;
    end else begin
      w_set_mode    = w_cmd_mode && is_mode_change_state(r_state);
      w_cmd_illegal = (w_cmd_start && (r_state != ST_READY)) ||
                      (w_cmd_step  && (r_state != ST_STEP_WAIT)) ||
                      (w_cmd_mode  && !is_mode_change_state(r_state));
      case (r_state)
        ST_IDLE:      w_next_state = ST_IDLE;
        ST_RESETTING: if (r_rst_cnt == 4'd0) w_next_state = ST_READY;
        ST_READY:     if (w_cmd_start) w_next_state = r_mode ? ST_STEP_WAIT : ST_RUN_CONT;
        ST_RUN_CONT:  if (i_halt) w_next_state = ST_HALTED;
        ST_STEP_WAIT: if (w_cmd_step) w_next_state = ST_STEP_EXEC;
        ST_STEP_EXEC: w_next_state = i_halt ? ST_HALTED : ST_STEP_WAIT;
        ST_HALTED:    w_next_state = ST_HALTED;
        default:      w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_prev_valid  <= 1'b1;
      r_rst_cnt     <= 4'd0;
      r_mode        <= 1'b0;
      r_mips_enable <= 1'b0;
      r_mips_reset  <= 1'b1;
      r_done        <= 1'b0;
      r_cmd_error   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_prev_valid <= i_instr_valid;
      // A RESET while already resetting reloads the timer.
      if (w_cmd_reset) begin
        r_rst_cnt <= RST_LOAD;
      end else if ((r_state == ST_RESETTING) && (r_rst_cnt != 4'd0)) begin
        r_rst_cnt <= r_rst_cnt - 4'd1;
      end
      if (w_set_mode) begin
        r_mode <= i_mode_sel;
      end
      r_mips_enable <= is_enabled_state(w_next_state);
      r_mips_reset  <= (w_next_state == ST_IDLE) || (w_next_state == ST_RESETTING);
      r_done        <= (w_next_state == ST_HALTED) && (r_state != ST_HALTED);
      r_cmd_error   <= w_cmd_illegal;
    end
  end

  sat_counter #(
    .WIDTH (NB_CYCLE_COUNT)
  ) u_cycle_counter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_cmd_reset),
    .i_enable (r_mips_enable),
    .o_count  (o_cycle_count)
  );

  assign o_mips_enable = r_mips_enable;
  assign o_mips_reset  = r_mips_reset;
  assign o_mode        = r_mode;
  assign o_state       = r_state;
  assign o_done        = r_done;
  assign o_cmd_error   = r_cmd_error;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed and randomized bench for mips_run_controller with a behavioural
// command/state reference model; a 4-bit counter instance checks saturation.
module tb_mips_run_controller;

  localparam logic [5:0] C_START    = 6'b000001;
  localparam logic [5:0] C_RESET    = 6'b000010;
  localparam logic [5:0] C_SET_MODE = 6'b001010;
  localparam logic [5:0] C_STEP     = 6'b100000;
  localparam int RST_CYC = 4;

  localparam int S_IDLE = 0, S_RESETTING = 1, S_READY = 2, S_RUN = 3,
                 S_WAIT = 4, S_EXEC = 5, S_HALTED = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  code;
  logic        valid;
  logic        sel;
  logic        halt;

  logic        en, mrst, mode, done, err;
  logic [2:0]  state;
  logic [31:0] cnt;
  logic        en4, mrst4, mode4, done4, err4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;

  int n_err = 0;
  int n_checks = 0;

  int     m_state;
  bit     m_prev_valid;
  bit     m_mode;
  longint m_count;
  int     m_rst_left;
  bit     m_done;
  bit     m_err;

  always #5 clk = ~clk;

  mips_run_controller dut (
    .i_clock(clk), .i_reset(rst_n), .i_instr_code(code), .i_instr_valid(valid),
    .i_mode_sel(sel), .i_halt(halt), .o_mips_enable(en), .o_mips_reset(mrst),
    .o_mode(mode), .o_state(state), .o_cycle_count(cnt), .o_done(done),
    .o_cmd_error(err)
  );

  mips_run_controller #(.NB_CYCLE_COUNT(4)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_instr_code(code), .i_instr_valid(valid),
    .i_mode_sel(sel), .i_halt(halt), .o_mips_enable(en4), .o_mips_reset(mrst4),
    .o_mode(mode4), .o_state(state4), .o_cycle_count(cnt4), .o_done(done4),
    .o_cmd_error(err4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_prev_valid = 1'b1; m_mode = 1'b0;
    m_count = 0; m_rst_left = 0; m_done = 1'b0; m_err = 1'b0;
  endtask

  // One rising edge of the spec-level behaviour, from the current inputs.
  task automatic model_clock();
    bit edge_v, c_rst, c_start, c_mode, c_step;
    int ns;
    edge_v = valid && !m_prev_valid;
    m_prev_valid = valid;
    c_rst   = edge_v && (code == C_RESET);
    c_start = edge_v && (code == C_START);
    c_mode  = edge_v && (code == C_SET_MODE);
    c_step  = edge_v && (code == C_STEP);
    ns = m_state;
    m_err = 1'b0;
    if (m_state == S_RUN || m_state == S_EXEC) m_count++;
    if (c_rst) begin
      ns = S_RESETTING; m_rst_left = RST_CYC; m_count = 0;
    end else begin
      if (c_start) begin
        if (m_state == S_READY) ns = m_mode ? S_WAIT : S_RUN; else m_err = 1'b1;
      end
      if (c_step) begin
        if (m_state == S_WAIT) ns = S_EXEC; else m_err = 1'b1;
      end
      if (c_mode) begin
        if (m_state inside {S_IDLE, S_READY, S_HALTED}) m_mode = sel; else m_err = 1'b1;
      end
      if (m_state == S_RESETTING) begin
        m_rst_left--;
        if (m_rst_left == 0) ns = S_READY;
      end
      if (m_state == S_EXEC) ns = S_WAIT;
      if ((m_state == S_RUN || m_state == S_EXEC) && halt) ns = S_HALTED;
    end
    m_done = (ns == S_HALTED) && (m_state != S_HALTED);
    m_state = ns;
  endtask

  task automatic chk_all(input string tag);
    longint sat4;
    sat4 = (m_count > 15) ? 15 : m_count;
    chk({tag, ".state"}, 64'(state), 64'(m_state));
    chk({tag, ".enable"}, 64'(en), 64'(m_state == S_RUN || m_state == S_EXEC));
    chk({tag, ".mips_reset"}, 64'(mrst), 64'(m_state == S_IDLE || m_state == S_RESETTING));
    chk({tag, ".mode"}, 64'(mode), 64'(m_mode));
    chk({tag, ".count"}, 64'(cnt), 64'(m_count) & 64'hFFFF_FFFF);
    chk({tag, ".done"}, 64'(done), 64'(m_done));
    chk({tag, ".cmd_error"}, 64'(err), 64'(m_err));
    chk({tag, ".count4"}, 64'(cnt4), 64'(sat4));
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
    chk_all("cyc");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Guarantees a low-valid cycle, then presents the command for one edge.
  task automatic cmd(input logic [5:0] c, input logic s);
    valid = 1'b0; tick();
    code = c; sel = s; valid = 1'b1; tick();
    valid = 1'b0;
  endtask

  initial begin
    code = C_RESET; valid = 1'b1; sel = 1'b0; halt = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_all("in_reset");
    rst_n = 1'b1;

    // Valid held high across reset release must not issue RESET.
    ticks(3);
    chk("held_valid.state", 64'(state), 64'd0);
    chk("held_valid.mips_reset", 64'(mrst), 64'd1);

    cmd(C_RESET, 1'b0);
    chk("reset_entry.state", 64'(state), 64'd1);
    ticks(3);
    chk("resetting_4th.mips_reset", 64'(mrst), 64'd1);
    tick();
    chk("after_reset.state", 64'(state), 64'd2);
    chk("after_reset.mips_reset", 64'(mrst), 64'd0);

    cmd(C_SET_MODE, 1'b0);
    cmd(C_START, 1'b0);
    chk("start_cont.state", 64'(state), 64'd3);
    chk("start_cont.enable", 64'(en), 64'd1);
    ticks(10);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt.count", 64'(cnt), 64'd11);
    chk("halt.done", 64'(done), 64'd1);
    chk("halt.state", 64'(state), 64'd6);
    tick();
    chk("halt_next.done", 64'(done), 64'd0);

    cmd(C_START, 1'b0);
    chk("start_in_halted.err", 64'(err), 64'd1);
    chk("start_in_halted.state", 64'(state), 64'd6);
    tick();
    chk("start_in_halted.err_clear", 64'(err), 64'd0);

    cmd(C_SET_MODE, 1'b1);
    cmd(C_RESET, 1'b0);
    ticks(4);
    cmd(C_START, 1'b0);
    chk("start_step.state", 64'(state), 64'd4);
    for (int k = 0; k < 3; k++) begin
      cmd(C_STEP, 1'b0);
      chk("step.enable", 64'(en), 64'd1);
      tick();
      chk("step_done.enable", 64'(en), 64'd0);
    end
    chk("step.count", 64'(cnt), 64'd3);

    cmd(C_SET_MODE, 1'b0);
    chk("mode_in_step_wait.err", 64'(err), 64'd1);
    cmd(C_RESET, 1'b0);
    ticks(4);
    cmd(C_SET_MODE, 1'b0);
    cmd(C_START, 1'b0);
    cmd(C_SET_MODE, 1'b1);
    chk("mode_in_run.err", 64'(err), 64'd1);
    chk("mode_in_run.state", 64'(state), 64'd3);
    chk("mode_in_run.mode", 64'(mode), 64'd0);
    ticks(20);
    chk("sat4.count", 64'(cnt4), 64'd15);

    // RESET edge coinciding with HALT: RESET wins.
    valid = 1'b0; tick();
    code = C_RESET; valid = 1'b1; halt = 1'b1; tick();
    valid = 1'b0; halt = 1'b0;
    chk("reset_vs_halt.state", 64'(state), 64'd1);
    chk("reset_vs_halt.count", 64'(cnt), 64'd0);
    chk("reset_vs_halt.done", 64'(done), 64'd0);
    ticks(4);

    for (int k = 0; k < 400; k++) begin
      int pick;
      if (valid) begin
        if ($urandom_range(0, 9) < 7) valid = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        pick = $urandom_range(0, 9);
        if (pick < 2)      code = C_START;
        else if (pick < 3) code = C_RESET;
        else if (pick < 5) code = C_SET_MODE;
        else if (pick < 8) code = C_STEP;
        else               code = 6'($urandom_range(0, 63));
        valid = 1'b1;
      end
      sel  = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 19) == 0);
      tick();
    end
    valid = 1'b0; halt = 1'b0;

    // Asynchronous reset in the middle of a continuous run.
    cmd(C_RESET, 1'b0);
    ticks(4);
    cmd(C_SET_MODE, 1'b0);
    cmd(C_START, 1'b0);
    ticks(3);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("resume_idle.state", 64'(state), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_run_controller.md
MIPS_RUN_CONTROLLER -- requirements
Module: mips_run_controller

Interface
REQ-001 Parameter NB_CODE, default 6, width of debug command code.
REQ-002 Parameter NB_CYCLE_COUNT, default 32, width of executed-cycle counter.
REQ-003 Parameter RESET_CYCLES, default 4, cycles o_mips_reset is held per RESET command; legal range 1..15.
REQ-004 i_clock  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_instr_code  in  NB_CODE  command code field of the debug frame.
REQ-007 i_instr_valid  in  1  command valid flag of the frame; level signal.
REQ-008 i_mode_sel  in  1  address bit 0 of the frame; 0 = continuous, 1 = step.
REQ-009 i_halt  in  1  MIPS reports HALT retired; level.
REQ-010 o_mips_enable  out  1  pipeline advance enable to MIPS.
REQ-011 o_mips_reset  out  1  active-high reset to MIPS datapath.
REQ-012 o_mode  out  1  current run mode (0 continuous, 1 step).
REQ-013 o_state  out  3  current state encoding.
REQ-014 o_cycle_count  out  NB_CYCLE_COUNT  number of enabled cycles since last RESET.
REQ-015 o_done  out  1  one-cycle pulse on entry to HALTED.
REQ-016 o_cmd_error  out  1  one-cycle pulse when a recognised command is illegal in current state.

Function
REQ-017 A command SHALL be accepted only on the rising edge of i_instr_valid (valid high, registered previous valid low); held-high valid SHALL issue no further commands.
REQ-018 Codes: START 6'b000001, RESET 6'b000010, SET_MODE 6'b001010, STEP 6'b100000; any other code SHALL be ignored silently.
REQ-019 Accepted command in cycle N SHALL be reflected in all outputs at cycle N+1; all outputs registered.
REQ-020 States: IDLE=0, RESETTING=1, READY=2, RUN_CONT=3, STEP_WAIT=4, STEP_EXEC=5, HALTED=6.
REQ-021 RESET SHALL be legal in every state: -> RESETTING, cycle count cleared to 0, mode preserved.
REQ-022 RESETTING SHALL assert o_mips_reset for exactly RESET_CYCLES cycles, then -> READY; a new RESET inside RESETTING SHALL restart the count.
REQ-023 SET_MODE SHALL be legal in IDLE, READY, HALTED only; latches i_mode_sel into o_mode; state unchanged.
REQ-024 START in READY SHALL -> RUN_CONT if o_mode=0, STEP_WAIT if o_mode=1.
REQ-025 STEP in STEP_WAIT SHALL -> STEP_EXEC for exactly one cycle, then -> STEP_WAIT.
REQ-026 o_mips_enable SHALL be 1 only in RUN_CONT and STEP_EXEC.
REQ-027 o_mips_reset SHALL be 1 in IDLE and RESETTING, 0 otherwise.
REQ-028 i_halt sampled high in RUN_CONT or STEP_EXEC SHALL -> HALTED next cycle; that sampled cycle SHALL still be counted.
REQ-029 In HALTED only RESET and SET_MODE are legal; o_done SHALL pulse on the first HALTED cycle only.
REQ-030 Any recognised command illegal in the current state SHALL pulse o_cmd_error and leave state unchanged.
REQ-031 Simultaneous RESET command and i_halt: RESET SHALL win.
REQ-032 o_cycle_count SHALL increment by 1 per cycle with o_mips_enable=1 and saturate at all-ones.
REQ-033 i_halt SHALL be ignored outside RUN_CONT and STEP_EXEC.

Reset
REQ-034 On i_reset low, asynchronously: state IDLE, o_mips_reset 1, o_mips_enable 0, o_mode 0, o_cycle_count 0, o_done 0, o_cmd_error 0, previous-valid register 1.
REQ-035 Previous-valid reset value 1 SHALL prevent a held-high valid after reset from issuing a command.
REQ-036 Reset deassertion mid-operation SHALL resume in IDLE; no command state survives.

Structure
REQ-037 Shared package mips_debug_pkg SHALL hold command codes, state encoding, NB_CODE and NB_CYCLE_COUNT defaults.
REQ-038 One sub-module, sat_counter (parameterised width, clear, enable, saturate), SHALL implement o_cycle_count.

Verification
REQ-039 Reset, valid held high with RESET code -> no command; state 0, o_mips_reset 1.
REQ-040 Valid edge RESET -> o_mips_reset 1 for 4 cycles, state 2; SET_MODE sel 0, START -> state 3, enable 1; i_halt after 10 cycles -> count 11, o_done single pulse, state 6.
REQ-041 SET_MODE sel 1, START -> state 4; three STEP edges -> three single-cycle enables, count 3.
REQ-042 START in HALTED and SET_MODE in RUN_CONT -> o_cmd_error one pulse each, state unchanged.
REQ-043 RESET edge same cycle as i_halt in RUN_CONT -> state 1, count 0, no o_done.
REQ-044 NB_CYCLE_COUNT=4, run 20 enabled cycles -> count holds 15.
